// File: rtl/controller_poll_regs_m.sv
// Frame-synchronous controller poll scheduler with a CPU-readable register bank.
// Each poll captures the button bytes and accumulates sticky pressed/released edges.
module controller_poll_regs_m #(
    parameter int  NUM_CONTROLLERS = 2,
    parameter int  FETCH_CYCLES    = 16,
    localparam int ADDR_W          = $clog2(NUM_CONTROLLERS) + 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         vsync,
    output logic                         start_fetch,
    input  logic [8*NUM_CONTROLLERS-1:0] controller_buttons_in,
    input  logic                         rd_en,
    input  logic [ADDR_W-1:0]            rd_addr,
    output logic [7:0]                   rd_data,
    output logic [8*NUM_CONTROLLERS-1:0] dbg_prev
);

    localparam int TIMER_W = (FETCH_CYCLES > 1) ? $clog2(FETCH_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_CAPTURE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [TIMER_W-1:0]   r_timer;
    logic [TIMER_W-1:0]   w_timer_next;
    logic                 r_start_fetch;
    logic                 w_start_next;
    logic                 w_capture;
    logic                 w_overrun;
    logic [6:0]           r_frame_count;
    logic                 r_missed;
    logic [7:0]           r_rd_data;
    logic [7:0]           w_rd_next;
    logic [ADDR_W-1:0]    w_idx;
    logic [1:0]           w_off;
    logic                 w_in_range;
    logic                 w_clr_status;

    logic [NUM_CONTROLLERS-1:0][7:0] w_current;
    logic [NUM_CONTROLLERS-1:0][7:0] w_pressed;
    logic [NUM_CONTROLLERS-1:0][7:0] w_released;

    assign w_idx        = rd_addr >> 2;
    assign w_off        = rd_addr[1:0];
    assign w_in_range   = (w_idx < ADDR_W'(NUM_CONTROLLERS));
    assign w_clr_status = rd_en && w_in_range && (w_off == 2'd3);

    // Poll sequencer: vsync arriving while a poll is in flight is dropped and flagged.
    always_comb begin
        w_state_next = r_state;
        w_timer_next = r_timer;
        w_start_next = 1'b0;
        w_capture    = 1'b0;
        w_overrun    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (vsync) begin
                    w_start_next = 1'b1;
                    w_timer_next = TIMER_W'(FETCH_CYCLES - 1);
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                w_overrun = vsync;
                if (r_timer == '0) begin
                    w_state_next = S_CAPTURE;
                end else begin
                    w_timer_next = r_timer - 1'b1;
                end
            end
            S_CAPTURE: begin
                w_overrun    = vsync;
                w_capture    = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_timer       <= '0;
            r_start_fetch <= 1'b0;
            r_frame_count <= '0;
            r_missed      <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_timer       <= w_timer_next;
            r_start_fetch <= w_start_next;
            if (w_capture) begin
                r_frame_count <= r_frame_count + 7'd1;
            end
            // A coincident ignored vsync wins over the read-clear.
            r_missed <= (w_clr_status ? 1'b0 : r_missed) | w_overrun;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CONTROLLERS; gi++) begin : g_ctrl
            logic [7:0] r_current;
            logic [7:0] r_prev;
            logic [7:0] r_pressed;
            logic [7:0] r_released;
            logic [7:0] w_cur;
            logic       w_sel;
            logic       w_clr_pressed;
            logic       w_clr_released;

            assign w_cur          = controller_buttons_in[8*gi +: 8];
            assign w_sel          = rd_en && (w_idx == ADDR_W'(gi));
            assign w_clr_pressed  = w_sel && (w_off == 2'd1);
            assign w_clr_released = w_sel && (w_off == 2'd2);

            // Edges are taken against the pre-capture byte; bits read this cycle are
            // dropped but edges arriving in the same cycle survive.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_current  <= 8'h00;
                    r_prev     <= 8'h00;
                    r_pressed  <= 8'h00;
                    r_released <= 8'h00;
                end else begin
                    if (w_capture) begin
                        r_current <= w_cur;
                        r_prev    <= r_current;
                    end
                    r_pressed  <= (w_clr_pressed ? 8'h00 : r_pressed)
                                | (w_capture ? (w_cur & ~r_current) : 8'h00);
                    r_released <= (w_clr_released ? 8'h00 : r_released)
                                | (w_capture ? (~w_cur & r_current) : 8'h00);
                end
            end

            assign w_current[gi]         = r_current;
            assign w_pressed[gi]         = r_pressed;
            assign w_released[gi]        = r_released;
            assign dbg_prev[8*gi +: 8]   = r_prev;
        end
    endgenerate

    // Out-of-range controller indices match no entry and read as zero.
    always_comb begin
        w_rd_next = 8'h00;
        for (int i = 0; i < NUM_CONTROLLERS; i++) begin
            if (w_idx == ADDR_W'(i)) begin
                case (w_off)
                    2'd0:    w_rd_next = w_current[i];
                    2'd1:    w_rd_next = w_pressed[i];
                    2'd2:    w_rd_next = w_released[i];
                    default: w_rd_next = {r_missed, r_frame_count};
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= 8'h00;
        end else if (rd_en) begin
            r_rd_data <= w_rd_next;
        end
    end

    assign start_fetch = r_start_fetch;
    assign rd_data     = r_rd_data;

endmodule

// File: tb/tb_controller_poll_regs_m.sv
// Directed bench for controller_poll_regs_m: table-driven register reads plus
// hand-written poll sequences for overrun, read-clear collision and wrap.
module tb_controller_poll_regs_m;

    localparam int NC     = 3;
    localparam int FETCH  = 16;
    localparam int ADDR_W = $clog2(NC) + 2;

    logic              clk;
    logic              rst;
    logic              vsync;
    logic              start_fetch;
    logic [8*NC-1:0]   buttons;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic [8*NC-1:0]   dbg_prev;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    controller_poll_regs_m #(
        .NUM_CONTROLLERS(NC),
        .FETCH_CYCLES   (FETCH)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .vsync                (vsync),
        .start_fetch          (start_fetch),
        .controller_buttons_in(buttons),
        .rd_en                (rd_en),
        .rd_addr              (rd_addr),
        .rd_data              (rd_data),
        .dbg_prev             (dbg_prev)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (start_fetch === 1'b1) pulses++;
    end

    typedef struct {
        int         k;
        int         off;
        logic [7:0] exp;
    } rd_vec_t;

    rd_vec_t tbl[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic rd(input int k, input int off, output logic [7:0] d);
        @(negedge clk);
        rd_en   = 1'b1;
        rd_addr = {k[1:0], off[1:0]};
        @(negedge clk);
        rd_en = 1'b0;
        d     = rd_data;
    endtask

    task automatic rd_check(input int k, input int off, input logic [7:0] exp);
        logic [7:0] d;
        string      nm;
        rd(k, off, d);
        nm = $sformatf("read k=%0d off=%0d", k, off);
        check(nm, {24'h0, d}, {24'h0, exp});
    endtask

    // One full poll: vsync at step 0, optional extra vsyncs in [ovr_lo, ovr_hi],
    // optional read issued at step rd_at (17 = the capture cycle); ends after capture.
    task automatic poll(input logic [8*NC-1:0] btn, input int ovr_lo, input int ovr_hi,
                        input int rd_at, input int rk, input int roff,
                        input bit chk_start, output logic [7:0] rv);
        rv = 8'h00;
        for (int n = 0; n <= 18; n++) begin
            @(negedge clk);
            if (rd_at > 0 && n == rd_at + 1) rv = rd_data;
            if (chk_start && n == 1) check("start_fetch high", {31'h0, start_fetch}, 32'h1);
            if (chk_start && n == 2) check("start_fetch low", {31'h0, start_fetch}, 32'h0);
            if (n == 0) buttons = btn;
            vsync   = (n == 0) || (ovr_lo > 0 && n >= ovr_lo && n <= ovr_hi);
            rd_en   = (rd_at > 0 && n == rd_at);
            rd_addr = {rk[1:0], roff[1:0]};
        end
    endtask

    initial begin
        logic [7:0] v;

        rst     = 1'b1;
        vsync   = 1'b0;
        buttons = '0;
        rd_en   = 1'b0;
        rd_addr = '0;
        repeat (3) @(negedge clk);
        check("reset rd_data", {24'h0, rd_data}, 32'h0);
        check("reset start_fetch", {31'h0, start_fetch}, 32'h0);
        rst = 1'b0;

        for (int k = 0; k < NC; k++)
            for (int o = 0; o < 4; o++)
                rd_check(k, o, 8'h00);
        check("no pulse without vsync", pulses, 32'd0);

        // Poll 1: all released
        poll('0, 0, 0, 0, 0, 0, 1'b1, v);
        rd_check(0, 3, 8'h01);

        // Polls 2 and 3 with no reads in between
        poll(24'hF0_3C_81, 0, 0, 0, 0, 0, 1'b1, v);
        poll(24'hF0_0C_01, 0, 0, 0, 0, 0, 1'b1, v);
        check("dbg_prev ctrl0/1", {16'h0, dbg_prev[15:0]}, 32'h3C81);

        tbl[0]  = '{0, 0, 8'h01};
        tbl[1]  = '{0, 1, 8'h81};
        tbl[2]  = '{0, 1, 8'h00};
        tbl[3]  = '{0, 2, 8'h80};
        tbl[4]  = '{0, 2, 8'h00};
        tbl[5]  = '{1, 0, 8'h0C};
        tbl[6]  = '{1, 1, 8'h3C};
        tbl[7]  = '{1, 2, 8'h30};
        tbl[8]  = '{2, 0, 8'hF0};
        tbl[9]  = '{2, 1, 8'hF0};
        tbl[10] = '{2, 2, 8'h00};
        tbl[11] = '{2, 1, 8'h00};
        tbl[12] = '{1, 3, 8'h03};
        tbl[13] = '{0, 3, 8'h03};
        for (int i = 0; i < 14; i++) rd_check(tbl[i].k, tbl[i].off, tbl[i].exp);

        @(negedge clk);
        check("rd_data hold", {24'h0, rd_data}, 32'h03);

        // Build pressed0=01, then collide a read of it with the capture adding 02
        poll(24'hF0_0C_00, 0, 0, 0, 0, 0, 1'b1, v);
        poll(24'hF0_0C_01, 0, 0, 0, 0, 0, 1'b1, v);
        poll(24'hF0_0C_03, 0, 0, 17, 0, 1, 1'b1, v);
        check("collision read pressed0", {24'h0, v}, 32'h01);
        rd_check(0, 1, 8'h02);
        rd_check(0, 2, 8'h01);

        // Overrun 3 cycles after the first vsync
        poll(24'hF0_0C_03, 3, 3, 0, 0, 0, 1'b1, v);
        check("one pulse per poll", pulses, 32'd7);
        rd_check(0, 3, 8'h87);
        rd_check(0, 3, 8'h07);

        // Status read coincident with an ignored vsync keeps missed
        poll(24'hF0_0C_03, 3, 4, 4, 1, 3, 1'b1, v);
        check("status read during overrun", {24'h0, v}, 32'h87);
        rd_check(2, 3, 8'h88);
        rd_check(2, 3, 8'h08);

        // Poll 9 arms pressed2 and missed, then run to 128 polls
        poll(24'hF1_0C_03, 3, 3, 0, 0, 0, 1'b1, v);
        for (int p = 0; p < 119; p++) poll(24'hF1_0C_03, 0, 0, 0, 0, 0, 1'b0, v);
        check("pulse count after 128 polls", pulses, 32'd128);
        rd_check(3, 1, 8'h00);
        rd_check(3, 3, 8'h00);
        rd_check(0, 3, 8'h80);
        rd_check(0, 3, 8'h00);
        rd_check(2, 1, 8'h01);
        rd_check(2, 1, 8'h00);

        // Reset in the middle of a poll aborts it
        @(negedge clk);
        buttons = 24'hFF_FF_FF;
        vsync   = 1'b1;
        @(negedge clk);
        vsync = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        rd_check(0, 0, 8'h00);
        rd_check(0, 1, 8'h00);
        rd_check(0, 3, 8'h00);

        poll(24'h00_00_55, 0, 0, 0, 0, 0, 1'b1, v);
        rd_check(0, 0, 8'h55);
        rd_check(0, 3, 8'h01);
        check("pulse count final", pulses, 32'd130);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
